cnu_ib_ram_loader: RTL and testbench



---
 rtl/ib_lut_pkg.sv | 19 +
 rtl/ib_word_unpacker.sv | 36 +++
 rtl/cnu_ib_ram_loader.sv | 120 ++++++++++++
 tb/tb_cnu_ib_ram_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ib_lut_pkg.sv
// Shared constants and loader state encoding for the CNU information-bottleneck LUT.
// Word packing (WORD_W/PACK) is derived here so the loader and unpacker agree on it.
package ib_lut_pkg;

    localparam int QUAN_SIZE   = 4;
    localparam int IB_ADDR     = 8;
    localparam int CARDINALITY = 1 << QUAN_SIZE;
    localparam int RAM_DEPTH   = 1 << IB_ADDR;
    localparam int WORD_W      = 16;
    localparam int PACK        = WORD_W / QUAN_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/ib_word_unpacker.sv
// Holds one packed LUT word and presents its entries LSB-first, one per shift.
// last flags the final entry of the word so the loader knows when to fetch again.
module ib_word_unpacker
    import ib_lut_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [WORD_W-1:0]    word,
    output logic [QUAN_SIZE-1:0] entry,
    output logic                 last
);

    localparam int ENT_W = (PACK > 1) ? $clog2(PACK) : 1;

    logic [WORD_W-1:0] shift_q;
    logic [ENT_W-1:0]  ent_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shift_q <= '0;
            ent_cnt <= '0;
        end else if (load) begin
            shift_q <= word;
            ent_cnt <= '0;
        end else if (shift) begin
            shift_q <= shift_q >> QUAN_SIZE;
            ent_cnt <= ent_cnt + ENT_W'(1);
        end
    end

    assign entry = shift_q[QUAN_SIZE-1:0];
    assign last  = (ent_cnt == ENT_W'(PACK - 1));

endmodule

// File: rtl/cnu_ib_ram_loader.sv
// Streams packed IB LUT words into the CNU LUT RAM write port, one entry per cycle.
// Optional IB_LOADER_CHECKSUM_EN adds a 12-bit entry sum compared against exp_checksum.
//
// state    | meaning
// ST_IDLE  | waiting for load_start
// ST_LOAD  | in_ready high, waiting for an input word
// ST_WRITE | writing the PACK entries of the held word
// ST_DONE  | one-cycle load_done pulse after the last entry
module cnu_ib_ram_loader
    import ib_lut_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 load_start,
    input  logic                 load_abort,
    input  logic [WORD_W-1:0]    in_word,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 ram_we,
    output logic [IB_ADDR-1:0]   ram_waddr,
    output logic [QUAN_SIZE-1:0] ram_wdata,
    output logic                 load_busy,
    output logic                 load_done
`ifdef IB_LOADER_CHECKSUM_EN
    ,
    input  logic [11:0]          exp_checksum,
    output logic                 checksum_ok
`endif
);

    if (RAM_DEPTH != (1 << IB_ADDR) || (RAM_DEPTH % PACK) != 0 ||
        (WORD_W % QUAN_SIZE) != 0 || CARDINALITY != (1 << QUAN_SIZE)) begin : g_bad_cfg
        $error("cnu_ib_ram_loader: inconsistent ib_lut_pkg geometry");
    end

    loader_state_e        state_q, state_d;
    logic [IB_ADDR-1:0]   addr_q;
    logic                 start_acc;
    logic                 take;
    logic                 wr;
    logic [QUAN_SIZE-1:0] entry;
    logic                 last;

    assign start_acc = (state_q == ST_IDLE) && load_start && !load_abort;
    assign take      = (state_q == ST_LOAD) && in_valid && !load_abort;
    assign wr        = (state_q == ST_WRITE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        ram_we    = 1'b0;
        load_busy = 1'b0;
        load_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready  = 1'b1;
                load_busy = 1'b1;
                if (in_valid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                ram_we    = 1'b1;
                load_busy = 1'b1;
                // Address reaching all-ones on the last entry means it wraps to 0: table complete.
                if (last) state_d = (addr_q == '1) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                load_done = 1'b1;
                load_busy = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (load_abort) state_d = ST_IDLE;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)        addr_q <= '0;
        else if (start_acc) addr_q <= '0;
        else if (wr)        addr_q <= addr_q + IB_ADDR'(1);
    end

    ib_word_unpacker u_unpacker (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (take),
        .shift   (wr),
        .word    (in_word),
        .entry   (entry),
        .last    (last)
    );

    assign ram_waddr = addr_q;
    assign ram_wdata = entry;

`ifdef IB_LOADER_CHECKSUM_EN
    logic [11:0] sum_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sum_q       <= '0;
            checksum_ok <= 1'b0;
        end else if (start_acc) begin
            sum_q       <= '0;
            checksum_ok <= 1'b0;
        end else begin
            if (wr) sum_q <= sum_q + 12'(entry);
            if (state_q == ST_DONE) checksum_ok <= (sum_q == exp_checksum);
        end
    end
`endif

endmodule

// File: tb/tb_cnu_ib_ram_loader.sv
// Directed bench for cnu_ib_ram_loader: full identity load, input stall, abort,
// mid-load reset with ignored load_start pulses, and the optional checksum.
module tb_cnu_ib_ram_loader;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        load_start;
    logic        load_abort;
    logic [15:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic        ram_we;
    logic [7:0]  ram_waddr;
    logic [3:0]  ram_wdata;
    logic        load_busy;
    logic        load_done;
`ifdef IB_LOADER_CHECKSUM_EN
    logic [11:0] exp_checksum;
    logic        checksum_ok;
`endif

    int tests = 0;
    int fails = 0;

    cnu_ib_ram_loader dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .load_start (load_start),
        .load_abort (load_abort),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ram_we     (ram_we),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .load_busy  (load_busy),
        .load_done  (load_done)
`ifdef IB_LOADER_CHECKSUM_EN
        ,
        .exp_checksum (exp_checksum),
        .checksum_ok  (checksum_ok)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mkword(input int k);
        logic [15:0] w;
        for (int j = 0; j < 4; j++) w[4*j +: 4] = 4'((4*k + j) & 15);
        return w;
    endfunction

    // Cycle c is the cycle after edge c, where edge 0 samples load_start.
    task automatic run_load(input int gap_addr, input int abort_addr, input int rst_addr,
                            input bit poke, output int nwrites, output int ndone,
                            output int done_cycle, output int first_we);
        int  exp_addr   = 0;
        int  gap_left   = 0;
        bit  gap_done   = 0;
        bit  after_evt  = 0;
        bit  after_done = 0;
        bit  finished   = 0;
        nwrites = 0; ndone = 0; done_cycle = -1; first_we = -1;
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_word    = mkword(0);
        tick();
        load_start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (after_evt) begin
                check("evt_ram_we", 32'(ram_we), 0);
                check("evt_busy", 32'(load_busy), 0);
                check("evt_done", 32'(load_done), 0);
                check("evt_in_ready", 32'(in_ready), 0);
                if (rst_addr >= 0) begin
                    check("rst_waddr", 32'(ram_waddr), 0);
                    check("rst_wdata", 32'(ram_wdata), 0);
                end
                load_abort = 1'b0;
                sys_rst    = 1'b0;
                finished   = 1;
                break;
            end
            if (after_done) begin
                check("post_done_busy", 32'(load_busy), 0);
                check("post_done_pulse", 32'(load_done), 0);
                check("post_done_we", 32'(ram_we), 0);
                finished = 1;
                break;
            end
            if (gap_left > 0) begin
                check("gap_in_ready", 32'(in_ready), 1);
                check("gap_ram_we", 32'(ram_we), 0);
                gap_left--;
                if (gap_left == 0) in_valid = 1'b1;
            end
            if (ram_we) begin
                if (first_we < 0) first_we = c;
                check("waddr", 32'(ram_waddr), 32'(exp_addr & 255));
                check("wdata", 32'(ram_wdata), 32'(exp_addr & 15));
                if (ram_waddr == abort_addr) begin load_abort = 1'b1; after_evt = 1; end
                if (ram_waddr == rst_addr)   begin sys_rst = 1'b1;    after_evt = 1; end
                exp_addr++;
                nwrites++;
            end
            if (load_done) begin
                ndone++;
                done_cycle = c;
                check("done_busy", 32'(load_busy), 1);
                after_done = 1;
            end
            if (gap_addr >= 0 && !gap_done && in_ready && exp_addr == gap_addr) begin
                in_valid = 1'b0;
                gap_left = 10;
                gap_done = 1;
            end
            in_word    = mkword(exp_addr >> 2);
            load_start = (poke && load_busy && (c % 23 == 7)) ? 1'b1 : 1'b0;
            tick();
        end
        load_start = 1'b0;
        check("load_terminated", 32'(finished), 1);
    endtask

    initial begin
        int nw, nd, dc, fw;
        sys_rst    = 1'b1;
        load_start = 1'b0;
        load_abort = 1'b0;
        in_word    = '0;
        in_valid   = 1'b0;
`ifdef IB_LOADER_CHECKSUM_EN
        exp_checksum = 12'h780;
`endif
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_waddr", 32'(ram_waddr), 0);
        check("rst_wdata", 32'(ram_wdata), 0);
        check("rst_busy", 32'(load_busy), 0);
        check("rst_done", 32'(load_done), 0);
`ifdef IB_LOADER_CHECKSUM_EN
        check("rst_checksum_ok", 32'(checksum_ok), 0);
`endif
        sys_rst = 1'b0;
        tick();
        check("idle_busy", 32'(load_busy), 0);

        // Full identity load with load_start pulses while busy.
        run_load(-1, -1, -1, 1'b1, nw, nd, dc, fw);
        check("full_nwrites", 32'(nw), 256);
        check("full_ndone", 32'(nd), 1);
        check("full_done_cycle", 32'(dc), 320);
        check("full_first_we", 32'(fw), 1);
`ifdef IB_LOADER_CHECKSUM_EN
        check("checksum_ok_match", 32'(checksum_ok), 1);
        exp_checksum = 12'h781;
`endif
        tick();

        // Stall of 10 cycles before the word starting at address 24.
        run_load(24, -1, -1, 1'b0, nw, nd, dc, fw);
        check("gap_nwrites", 32'(nw), 256);
        check("gap_ndone", 32'(nd), 1);
        check("gap_done_cycle", 32'(dc), 330);
`ifdef IB_LOADER_CHECKSUM_EN
        check("checksum_ok_mismatch", 32'(checksum_ok), 0);
`endif
        tick();

        // Abort right after the write to 0x42.
        run_load(-1, 8'h42, -1, 1'b0, nw, nd, dc, fw);
        check("abort_nwrites", 32'(nw), 32'h43);
        check("abort_ndone", 32'(nd), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_idle_done", 32'(load_done), 0);
            check("abort_idle_we", 32'(ram_we), 0);
        end

        // Restart after abort begins again at address 0.
        run_load(-1, -1, -1, 1'b0, nw, nd, dc, fw);
        check("restart_nwrites", 32'(nw), 256);
        check("restart_done_cycle", 32'(dc), 320);
        tick();

        // Reset right after the write to 0x80, with ignored load_start pulses.
        run_load(-1, -1, 8'h80, 1'b1, nw, nd, dc, fw);
        check("rst_mid_nwrites", 32'(nw), 32'h81);
        check("rst_mid_ndone", 32'(nd), 0);
        tick();
        check("rst_mid_idle_busy", 32'(load_busy), 0);
        check("rst_mid_idle_ready", 32'(in_ready), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
